// File: rtl/conv_pkg.sv
// Shared definitions for the conv engine read/write muxes: info field
// positions, burst FSM encoding, channel lane mask and RGB565 packing.
package conv_pkg;

  localparam int RAM_SEL_B = 4;   // info bit: RAM bank select
  localparam int MEM_SEL_B = 3;   // info bit: 1 = SDRAM, 0 = on-chip RAM
  localparam int CH_LSB    = 0;   // info channel field LSB
  localparam int CH_W      = 3;   // info channel field width
  localparam int MASK_W    = 8;   // lanes addressable by the channel field
  localparam int LANE_W    = 8;   // lane width assumed by the RGB565 packer
  localparam int PIX_W     = 16;  // RGB565 pixel width

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Channel 0 enables every lane; channel n enables lanes 0..n-1.
  function automatic logic [MASK_W-1:0] ch_mask(input logic [CH_W-1:0] ch);
    if (ch == '0) ch_mask = '1;
    else          ch_mask = (MASK_W'(1) << ch) - MASK_W'(1);
  endfunction

  // Truncating RGB565 pack: lane2 -> R[4:0], lane1 -> G[5:0], lane0 -> B[4:0].
  function automatic logic [PIX_W-1:0] rgb565(input logic [LANE_W-1:0] l0,
                                              input logic [LANE_W-1:0] l1,
                                              input logic [LANE_W-1:0] l2);
    rgb565 = {l2[7:3], l1[7:2], l0[7:3]};
  endfunction

endpackage

// File: rtl/axi_frs.sv
// Forward register slice: one-entry valid/data register whose input ready
// only depends on the slice state and the downstream ready.
module axi_frs #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  // Accept a new entry when empty or when the current one drains this cycle.
  assign in_ready  = ~valid_reg | out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  // Slice register; data only moves on an accepted load so it holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      if (in_ready)
        valid_reg <= in_valid;
      if (in_valid && in_ready)
        data_reg <= in_data;
    end
  end

endmodule

// File: rtl/wmux.sv
// Write mux: joins the conv write-address and write-data streams into beats
// and routes each burst to the on-chip RAM port or the SDRAM RGB565 port.
module wmux
  import conv_pkg::*;
#(
  parameter int DW0 = 16,
  parameter int DW  = 8,
  parameter int DN  = 8,
  parameter int IFW = 5,
  parameter int AW  = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IFW-1:0]   info,
  input  logic [AW-1:0]    m_addr,
  input  logic             m_addr_first,
  input  logic             m_addr_last,
  input  logic             m_addr_valid,
  output logic             m_addr_ready,
  input  logic [DN*DW-1:0] m_data,
  input  logic             m_data_first,
  input  logic             m_data_last,
  input  logic             m_data_valid,
  output logic             m_data_ready,
  output logic             s_ram_sel,
  output logic [AW-1:0]    s_waddr0,
  output logic [DN*DW-1:0] s_wdata0,
  output logic [DN-1:0]    s_wstrb0,
  output logic             s_wfirst0,
  output logic             s_wlast0,
  output logic             s_wvalid0,
  input  logic             s_wready0,
  output logic [AW-1:0]    s_waddr1,
  output logic [DW0-1:0]   s_wdata1,
  output logic             s_wfirst1,
  output logic             s_wlast1,
  output logic             s_wvalid1,
  input  logic             s_wready1,
  output logic             err
);

  localparam int W0 = AW + DN*DW + DN + 3;
  localparam int W1 = AW + DW0 + 2;

  state_t            state_reg, state_next;
  logic              ram_sel_reg, ram_sel_next;
  logic              mem_sel_reg, mem_sel_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic              err_reg, err_next;

  logic              idle;
  logic              dest_sdram;
  logic              beat_ram_sel;
  logic [CH_W-1:0]   beat_ch;
  logic [MASK_W-1:0] full_mask;
  logic [DN-1:0]     lane_mask;
  logic [DN*DW-1:0]  masked_data;
  logic [DW0-1:0]    pix;
  logic              rdy0, rdy1, dest_ok, fire;
  logic [W0-1:0]     ram_in, ram_out;
  logic [W1-1:0]     sd_in, sd_out;

  // In IDLE the live info steers the beat; inside a burst the latched copy does.
  assign idle         = (state_reg == ST_IDLE);
  assign dest_sdram   = idle ? info[MEM_SEL_B] : mem_sel_reg;
  assign beat_ram_sel = idle ? info[RAM_SEL_B] : ram_sel_reg;
  assign beat_ch      = idle ? info[CH_LSB +: CH_W] : ch_reg;
  assign full_mask    = ch_mask(beat_ch);

  generate
    for (genvar gi = 0; gi < DN; gi++) begin : g_lane
      if (gi < MASK_W) begin : g_ch
        assign lane_mask[gi] = full_mask[gi];
      end else begin : g_all
        assign lane_mask[gi] = (beat_ch == '0);
      end
      assign masked_data[gi*DW +: DW] = lane_mask[gi] ? m_data[gi*DW +: DW] : '0;
    end
  endgenerate

  assign pix = DW0'(rgb565(masked_data[0 +: LANE_W],
                           masked_data[DW +: LANE_W],
                           masked_data[2*DW +: LANE_W]));

  // Both streams are consumed together, only when the chosen slice can take it.
  assign dest_ok      = dest_sdram ? rdy1 : rdy0;
  assign fire         = m_addr_valid & m_data_valid & dest_ok;
  assign m_addr_ready = fire;
  assign m_data_ready = fire;
  assign err          = err_reg;

  assign ram_in = {beat_ram_sel, m_addr, masked_data, lane_mask, m_addr_first, m_addr_last};
  assign sd_in  = {m_addr, pix, m_addr_first, m_addr_last};

  axi_frs #(.W(W0)) u_ram_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (ram_in),
    .in_valid (fire & ~dest_sdram),
    .in_ready (rdy0),
    .out_data (ram_out),
    .out_valid(s_wvalid0),
    .out_ready(s_wready0)
  );

  axi_frs #(.W(W1)) u_sdram_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (sd_in),
    .in_valid (fire & dest_sdram),
    .in_ready (rdy1),
    .out_data (sd_out),
    .out_valid(s_wvalid1),
    .out_ready(s_wready1)
  );

  assign {s_ram_sel, s_waddr0, s_wdata0, s_wstrb0, s_wfirst0, s_wlast0} = ram_out;
  assign {s_waddr1, s_wdata1, s_wfirst1, s_wlast1} = sd_out;

  // Burst FSM, info latch and protocol-error detection on each joint beat.
  always_comb begin
    state_next   = state_reg;
    ram_sel_next = ram_sel_reg;
    mem_sel_next = mem_sel_reg;
    ch_next      = ch_reg;
    err_next     = err_reg;
    if (fire) begin
      if ((m_addr_first != m_data_first) || (m_addr_last != m_data_last))
        err_next = 1'b1;
      case (state_reg)
        ST_IDLE: begin
          // A missing first flag is flagged but still opens a burst.
          ram_sel_next = info[RAM_SEL_B];
          mem_sel_next = info[MEM_SEL_B];
          ch_next      = info[CH_LSB +: CH_W];
          if (!m_addr_first) err_next = 1'b1;
          if (!m_addr_last)  state_next = ST_BURST;
        end
        ST_BURST: begin
          if (m_addr_first) err_next = 1'b1;
          if (m_addr_last)  state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State, latched info and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ram_sel_reg <= 1'b0;
      mem_sel_reg <= 1'b0;
      ch_reg      <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ram_sel_reg <= ram_sel_next;
      mem_sel_reg <= mem_sel_next;
      ch_reg      <= ch_next;
      err_reg     <= err_next;
    end
  end

endmodule

// File: tb/tb_wmux.sv
// Scoreboard bench for wmux: expected beats are queued when the joint beat is
// accepted and checked against each output handshake.
module tb_wmux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  info;
  logic [12:0] m_addr;
  logic        m_addr_first, m_addr_last, m_addr_valid, m_addr_ready;
  logic [63:0] m_data;
  logic        m_data_first, m_data_last, m_data_valid, m_data_ready;
  logic        s_ram_sel;
  logic [12:0] s_waddr0;
  logic [63:0] s_wdata0;
  logic [7:0]  s_wstrb0;
  logic        s_wfirst0, s_wlast0, s_wvalid0, s_wready0;
  logic [12:0] s_waddr1;
  logic [15:0] s_wdata1;
  logic        s_wfirst1, s_wlast1, s_wvalid1, s_wready1;
  logic        err;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [12:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        first;
    logic        last;
    logic        ram_sel;
  } ram_beat_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] pix;
    logic        first;
    logic        last;
  } sd_beat_t;

  ram_beat_t q0[$];
  sd_beat_t  q1[$];
  ram_beat_t e0, a0;
  sd_beat_t  e1, a1;

  always #5 clk = ~clk;

  wmux dut (
    .clk(clk), .rst_n(rst_n), .info(info),
    .m_addr(m_addr), .m_addr_first(m_addr_first), .m_addr_last(m_addr_last),
    .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
    .m_data(m_data), .m_data_first(m_data_first), .m_data_last(m_data_last),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
    .s_ram_sel(s_ram_sel), .s_waddr0(s_waddr0), .s_wdata0(s_wdata0),
    .s_wstrb0(s_wstrb0), .s_wfirst0(s_wfirst0), .s_wlast0(s_wlast0),
    .s_wvalid0(s_wvalid0), .s_wready0(s_wready0),
    .s_waddr1(s_waddr1), .s_wdata1(s_wdata1), .s_wfirst1(s_wfirst1),
    .s_wlast1(s_wlast1), .s_wvalid1(s_wvalid1), .s_wready1(s_wready1),
    .err(err)
  );

  // Reference model: lane mask, masked data and RGB565 pixel.
  function automatic logic [7:0] exp_mask(input logic [2:0] ch);
    if (ch == 3'd0) return 8'hFF;
    return 8'hFF >> (8 - int'(ch));
  endfunction

  function automatic logic [63:0] exp_data(input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [15:0] exp_pix(input logic [63:0] md);
    return {md[23:19], md[15:10], md[7:3]};
  endfunction

  task automatic push_expected(input logic [4:0] gov, input logic [12:0] addr,
                               input logic [63:0] data, input logic f, input logic l);
    logic [7:0]  m;
    logic [63:0] md;
    m  = exp_mask(gov[2:0]);
    md = exp_data(data, m);
    if (gov[3]) q1.push_back('{addr: addr, pix: exp_pix(md), first: f, last: l});
    else        q0.push_back('{addr: addr, data: md, strb: m, first: f, last: l, ram_sel: gov[4]});
  endtask

  // Output monitor: every handshake on either port must match the queue head.
  always @(negedge clk) begin
    if (s_wvalid0 && s_wready0) begin
      a0 = '{addr: s_waddr0, data: s_wdata0, strb: s_wstrb0, first: s_wfirst0,
             last: s_wlast0, ram_sel: s_ram_sel};
      $display("ram   beat addr=%h data=%h strb=%h first=%b last=%b sel=%b",
               a0.addr, a0.data, a0.strb, a0.first, a0.last, a0.ram_sel);
      total++;
      if (q0.size() == 0) begin
        $display("FAIL ram_unexpected got addr=%h data=%h want no beat", a0.addr, a0.data);
      end else begin
        e0 = q0.pop_front();
        if (a0 !== e0)
          $display("FAIL ram_beat got addr=%h data=%h strb=%h f=%b l=%b sel=%b want addr=%h data=%h strb=%h f=%b l=%b sel=%b",
                   a0.addr, a0.data, a0.strb, a0.first, a0.last, a0.ram_sel,
                   e0.addr, e0.data, e0.strb, e0.first, e0.last, e0.ram_sel);
        else passed++;
      end
    end
    if (s_wvalid1 && s_wready1) begin
      a1 = '{addr: s_waddr1, pix: s_wdata1, first: s_wfirst1, last: s_wlast1};
      $display("sdram beat addr=%h pix=%h first=%b last=%b", a1.addr, a1.pix, a1.first, a1.last);
      total++;
      if (q1.size() == 0) begin
        $display("FAIL sdram_unexpected got addr=%h pix=%h want no beat", a1.addr, a1.pix);
      end else begin
        e1 = q1.pop_front();
        if (a1 !== e1)
          $display("FAIL sdram_beat got addr=%h pix=%h f=%b l=%b want addr=%h pix=%h f=%b l=%b",
                   a1.addr, a1.pix, a1.first, a1.last, e1.addr, e1.pix, e1.first, e1.last);
        else passed++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one joint beat and wait (bounded) for it to be accepted.
  task automatic send_beat(input logic [4:0] drv_info, input logic [4:0] gov_info,
                           input logic [12:0] addr, input logic [63:0] data,
                           input logic af, input logic al, input logic df, input logic dl);
    bit acc;
    acc = 1'b0;
    info = drv_info;
    m_addr = addr; m_addr_first = af; m_addr_last = al; m_addr_valid = 1'b1;
    m_data = data; m_data_first = df; m_data_last = dl; m_data_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (m_addr_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
    end
    total++;
    if (!acc) $display("FAIL send_timeout addr=%h got ready=%b want 1", addr, m_addr_ready);
    else if (m_data_ready !== 1'b1) $display("FAIL data_ready got=%b want=1", m_data_ready);
    else passed++;
    if (acc) push_expected(gov_info, addr, data, af, al);
    @(posedge clk);
    #1;
    m_addr_valid = 1'b0;
    m_data_valid = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({s_wvalid0, s_wvalid1, err, s_ram_sel} !== 4'b0000)
      $display("FAIL reset_flags got v0=%b v1=%b err=%b sel=%b want 0000", s_wvalid0, s_wvalid1, err, s_ram_sel);
    else passed++;
    total++;
    if (s_wdata0 !== 64'd0 || s_wdata1 !== 16'd0 || s_waddr0 !== 13'd0 || s_wstrb0 !== 8'd0)
      $display("FAIL reset_data got d0=%h d1=%h a0=%h s0=%h want zeros", s_wdata0, s_wdata1, s_waddr0, s_wstrb0);
    else passed++;
    rst_n = 1'b1;
    idle(2);
    total++;
    if (s_wvalid0 !== 1'b0 || s_wvalid1 !== 1'b0 || m_addr_ready !== 1'b0)
      $display("FAIL post_reset_idle got v0=%b v1=%b rdy=%b want 000", s_wvalid0, s_wvalid1, m_addr_ready);
    else passed++;
  endtask

  task automatic test_single_ram;
    idle(2);
    send_beat(5'b1_0_000, 5'b1_0_000, 13'h0010, 64'h0807060504030201, 1, 1, 1, 1);
    // Next beat uses live info again: only true if the FSM stayed in IDLE.
    send_beat(5'b0_1_000, 5'b0_1_000, 13'h0011, 64'h00000000_00A0B0C0, 1, 1, 1, 1);
    idle(2);
    total++;
    if (err !== 1'b0) $display("FAIL single_err got=%b want=0", err);
    else passed++;
  endtask

  task automatic test_sdram_burst;
    logic [63:0] d;
    idle(2);
    d = 64'hABCDEF1234_F8FCF8;
    for (int b = 0; b < 4; b++)
      send_beat((b >= 2) ? 5'b1_0_000 : 5'b0_1_011, 5'b0_1_011, 13'h0100 + 13'(b), d,
                b == 0, b == 3, b == 0, b == 3);
    idle(2);
    total++;
    if (exp_pix(exp_data(d, exp_mask(3'd3))) !== 16'hFFFF || err !== 1'b0)
      $display("FAIL burst_pix_err got pix=%h err=%b want FFFF 0",
               exp_pix(exp_data(d, exp_mask(3'd3))), err);
    else passed++;
  endtask

  task automatic test_channel_mask;
    idle(2);
    send_beat(5'b1_0_011, 5'b1_0_011, 13'h0200, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 1);
    send_beat(5'b0_0_110, 5'b0_0_110, 13'h0201, 64'h1122334455667788, 1, 1, 1, 1);
    send_beat(5'b0_0_001, 5'b0_0_001, 13'h0202, 64'h1122334455667788, 1, 1, 1, 1);
  endtask

  task automatic test_backpressure;
    logic [63:0] d [6];
    idle(2);
    for (int b = 0; b < 6; b++) d[b] = {$urandom, $urandom};
    s_wready1 = 1'b0;
    send_beat(5'b0_1_000, 5'b0_1_000, 13'h0300, d[0], 1, 0, 1, 0);
    fork
      begin
        for (int b = 1; b < 6; b++)
          send_beat(5'b0_1_000, 5'b0_1_000, 13'h0300 + 13'(b), d[b], 0, b == 5, 0, b == 5);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          total++;
          if (m_addr_ready !== 1'b0 || m_data_ready !== 1'b0)
            $display("FAIL bp_ready got a=%b d=%b want 00", m_addr_ready, m_data_ready);
          else passed++;
          total++;
          if (s_wvalid1 !== 1'b1 || s_waddr1 !== 13'h0300 || s_wfirst1 !== 1'b1 ||
              s_wdata1 !== exp_pix(d[0]))
            $display("FAIL bp_hold got v=%b a=%h f=%b pix=%h want 1 0300 1 %h",
                     s_wvalid1, s_waddr1, s_wfirst1, s_wdata1, exp_pix(d[0]));
          else passed++;
        end
        @(posedge clk);
        #1;
        s_wready1 = 1'b1;
      end
    join
  endtask

  task automatic test_skew;
    idle(3);
    info = 5'b1_0_000;
    m_addr = 13'h0400; m_addr_first = 1'b1; m_addr_last = 1'b1; m_addr_valid = 1'b1;
    m_data = 64'h0123456789ABCDEF; m_data_first = 1'b1; m_data_last = 1'b1; m_data_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (m_addr_ready !== 1'b0 || s_wvalid0 !== 1'b0)
        $display("FAIL skew_wait got rdy=%b v0=%b want 00", m_addr_ready, s_wvalid0);
      else passed++;
    end
    @(posedge clk);
    #1;
    m_data_valid = 1'b1;
    @(negedge clk);
    total++;
    if (m_addr_ready !== 1'b1) $display("FAIL skew_fire got rdy=%b want 1", m_addr_ready);
    else passed++;
    if (m_addr_ready === 1'b1) push_expected(5'b1_0_000, 13'h0400, 64'h0123456789ABCDEF, 1, 1);
    @(posedge clk);
    #1;
    m_addr_valid = 1'b0;
    m_data_valid = 1'b0;
  endtask

  task automatic test_error;
    idle(2);
    send_beat(5'b0_0_000, 5'b0_0_000, 13'h0500, 64'h5555AAAA5555AAAA, 1, 1, 1, 0);
    idle(1);
    total++;
    if (err !== 1'b1) $display("FAIL err_flag_mismatch got=%b want=1", err);
    else passed++;
    // Address last closed the burst, so live info picks SDRAM here.
    send_beat(5'b0_1_010, 5'b0_1_010, 13'h0501, 64'h00000000_0010FF80, 1, 1, 1, 1);
    idle(3);
    total++;
    if (err !== 1'b1) $display("FAIL err_sticky got=%b want=1", err);
    else passed++;
  endtask

  task automatic test_reset_mid_burst;
    idle(2);
    s_wready0 = 1'b0;
    send_beat(5'b1_0_000, 5'b1_0_000, 13'h0600, 64'hDEADBEEFDEADBEEF, 1, 0, 1, 0);
    info = 5'b1_0_000;
    m_addr = 13'h0601; m_addr_first = 1'b0; m_addr_last = 1'b0; m_addr_valid = 1'b1;
    m_data_first = 1'b0; m_data_last = 1'b0; m_data_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (s_wvalid0 !== 1'b0 || s_wdata0 !== 64'd0 || s_waddr0 !== 13'd0 || err !== 1'b0 || s_ram_sel !== 1'b0)
      $display("FAIL midreset got v0=%b d0=%h a0=%h err=%b sel=%b want zeros",
               s_wvalid0, s_wdata0, s_waddr0, err, s_ram_sel);
    else passed++;
    m_addr_valid = 1'b0;
    m_data_valid = 1'b0;
    q0.delete();
    s_wready0 = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    // FSM must be back in IDLE: live info routes this beat to SDRAM.
    send_beat(5'b0_1_000, 5'b0_1_000, 13'h0610, 64'h00000000_00123456, 1, 1, 1, 1);
    idle(2);
    total++;
    if (err !== 1'b0) $display("FAIL midreset_err got=%b want=0", err);
    else passed++;
    // IDLE beat without first: flagged, treated as first, info latched.
    send_beat(5'b1_0_010, 5'b1_0_010, 13'h0620, 64'h99887766554433CC, 0, 1, 0, 1);
    idle(2);
    total++;
    if (err !== 1'b1) $display("FAIL implicit_first_err got=%b want=1", err);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    info = '0;
    m_addr = '0; m_addr_first = 1'b0; m_addr_last = 1'b0; m_addr_valid = 1'b0;
    m_data = '0; m_data_first = 1'b0; m_data_last = 1'b0; m_data_valid = 1'b0;
    s_wready0 = 1'b1;
    s_wready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_single_ram;
    test_sdram_burst;
    test_channel_mask;
    test_backpressure;
    test_skew;
    test_error;
    test_reset_mid_burst;
    idle(5);
    total++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL drain got ram_left=%0d sdram_left=%0d want 0 0", q0.size(), q1.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
